// File: rtl/div_pkg.sv
// Shared types and constants for the non-restoring divider controller.
package div_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_ITERS = DEF_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIXUP,
        ST_SIGN,
        ST_DONE
    } state_t;
endpackage

// File: rtl/div_step.sv
// One combinational non-restoring division step on {A,Q} with divisor B.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out
);
    logic [WIDTH:0] a_sh;
    logic [WIDTH:0] b_ext;

    always_comb begin
        a_sh  = {a_in[WIDTH-1:0], q_in[WIDTH-1]};
        b_ext = {1'b0, b_in};
        // Sign of the pre-shift accumulator chooses subtract or restore-by-add.
        a_out = a_in[WIDTH] ? (a_sh + b_ext) : (a_sh - b_ext);
        q_out = {q_in[WIDTH-2:0], ~a_out[WIDTH]};
    end
endmodule

// File: rtl/div_ctrl.sv
// Sequential signed/unsigned divider: one non-restoring step per cycle.
// state | meaning
// IDLE  | waiting for start; operands captured on start
// PREP  | abs values, record result signs, clear A, load counter
// ITER  | one div_step per cycle, ITERS cycles
// FIXUP | restore negative remainder
// SIGN  | apply recorded signs, publish results
// DONE  | done pulse, back to IDLE
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(ITERS + 1);

    state_t             state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d, b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sop_q, sop_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic [WIDTH-1:0]   quot_q, quot_d, rem_q, rem_d;
    logic [WIDTH:0]     a_step;
    logic [WIDTH-1:0]   q_step, rem_raw;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a_in  (a_q),
        .q_in  (q_q),
        .b_in  (b_q),
        .a_out (a_step),
        .q_out (q_step)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        sop_d   = sop_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        rem_raw = a_q[WIDTH-1:0];
        if (state_q == ST_IDLE) begin
            if (start && !flush) begin
                q_d     = dividend;
                b_d     = divisor;
                sop_d   = signed_op;
                state_d = ST_PREP;
                busy_d  = 1'b1;
            end
        end else if (flush) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_PREP: begin
                    qneg_d = sop_q & (q_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    rneg_d = sop_q & q_q[WIDTH-1];
                    a_d    = '0;
                    cnt_d  = CNT_W'(ITERS);
                    if (sop_q && q_q[WIDTH-1]) q_d = -q_q;
                    if (sop_q && b_q[WIDTH-1]) b_d = -b_q;
                    if (b_q == '0) begin
                        // Raw dividend is still in Q because nothing was negated yet.
                        quot_d  = '1;
                        rem_d   = q_q;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ITER;
                    end
                end
                ST_ITER: begin
                    a_d   = a_step;
                    q_d   = q_step;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = ST_FIXUP;
                end
                ST_FIXUP: begin
                    if (a_q[WIDTH]) a_d = a_q + {1'b0, b_q};
                    state_d = ST_SIGN;
                end
                ST_SIGN: begin
                    quot_d  = qneg_q ? -q_q : q_q;
                    rem_d   = rneg_q ? -rem_raw : rem_raw;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            sop_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            sop_q   <= sop_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed divides, flush, reset and busy-start cases.
module tb_div_ctrl;
    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    div_ctrl dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (clear_n && done === 1'b1) begin : mon
            exp_t e;
            check("done_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", div_by_zero, e.dz);
                check("latency", 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    task automatic issue(input logic sop, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int lat);
        exp_t e;
        signed_op = sop;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (push) begin
            e.q = eq; e.r = er; e.dz = edz; e.lat = lat; e.t0 = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 120 && sb.size() > 0; i++) @(negedge clk);
        check("drain_timeout", 64'(sb.size()), 64'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        clear_n = 1'b1;
        @(negedge clk);

        issue(0, 32'd100, 32'd7, 1, 32'd14, 32'd2, 0, 35);
        drain();
        issue(1, 32'hFFFFFF9C, 32'd7, 1, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, 35);
        drain();
        issue(1, 32'd100, 32'hFFFFFFF9, 1, 32'hFFFFFFF2, 32'd2, 0, 35);
        drain();
        issue(0, 32'h1234, 32'd0, 1, 32'hFFFFFFFF, 32'h1234, 1, 1);
        drain();
        issue(1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 32'd0, 0, 35);
        drain();
        issue(0, 32'hFFFFFFFF, 32'd1, 1, 32'hFFFFFFFF, 32'd0, 0, 35);
        drain();
        issue(1, 32'hFFFFFF9C, 32'hFFFFFFF9, 1, 32'd14, 32'hFFFFFFFE, 0, 35);
        drain();

        // Starts while busy must be neither executed nor queued.
        issue(0, 32'd50, 32'd5, 1, 32'd10, 32'd0, 0, 35);
        @(negedge clk);
        check("busy_mid_op", busy, 1);
        repeat (5) @(negedge clk);
        issue(0, 32'd200, 32'd3, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        issue(1, 32'hFFFFFFF7, 32'd2, 0, 0, 0, 0, 0);
        drain();
        repeat (40) @(negedge clk);
        check("idle_after_busy_starts", busy, 0);

        // Flush mid-operation: no done, previous results held.
        issue(0, 32'd77, 32'd7, 0, 0, 0, 0, 0);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", busy, 0);
        repeat (40) @(negedge clk);
        check("flush_quotient_held", quotient, 32'd10);
        check("flush_remainder_held", remainder, 32'd0);

        // Flush wins over start in IDLE.
        flush = 1'b1;
        issue(0, 32'd9, 32'd4, 0, 0, 0, 0, 0);
        flush = 1'b0;
        @(negedge clk);
        check("flush_beats_start", busy, 0);
        issue(0, 32'd9, 32'd4, 1, 32'd2, 32'd1, 0, 35);
        drain();

        // Start presented in the DONE cycle is dropped.
        issue(0, 32'd100, 32'd7, 1, 32'd14, 32'd2, 0, 35);
        for (int i = 0; i < 60 && done !== 1'b1; i++) @(negedge clk);
        check("done_seen", done, 1);
        issue(0, 32'd8, 32'd2, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("start_in_done_ignored", busy, 0);
        repeat (45) @(negedge clk);

        // Reset mid-operation.
        issue(0, 32'd50, 32'd5, 0, 0, 0, 0, 0);
        repeat (18) @(negedge clk);
        clear_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_quotient", quotient, 0);
        check("mid_rst_remainder", remainder, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        @(negedge clk);
        clear_n = 1'b1;
        repeat (45) @(negedge clk);
        check("post_rst_idle", busy, 0);
        check("post_rst_quotient", quotient, 0);
        check("queue_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
